qpmm_issue_arbiter: RTL and testbench
=====================================

Name: qpmm_issue_arbiter

Overview:
- Shares one fully pipelined QPMM Montgomery multiplier (initiation interval 1, fixed latency, no valid/ready of its own) among NUM_REQ requesters.
- Round-robin arbitration, registered operand issue, and a latency-matched valid/ID/tag delay line that re-associates each Z with its requester.
- Sits between the pairing-engine sequencers (requesters) and the multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FP_W, 256, operand/result width (width of qpmm_fp_t).
- TAG_W, 4, requester-private tag width, returned unchanged.
- QPMM_LAT, 64, cycles from multiplier A/B input to Z output.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*FP_W  operand A, requester r at slice r
- req_b  in  NUM_REQ*FP_W  operand B, requester r at slice r
- req_tag  in  NUM_REQ*TAG_W  request tag, requester r at slice r
- issue_en  in  1  0 blocks new grants; in-flight operations drain
- mul_a  out  FP_W  to multiplier A
- mul_b  out  FP_W  to multiplier B
- mul_z  in  FP_W  from multiplier Z
- rsp_valid  out  1  response valid, one cycle, no backpressure
- rsp_id  out  clog2(NUM_REQ)  requester index of the response
- rsp_tag  out  TAG_W  tag of the response
- rsp_z  out  FP_W  result
- idle  out  1  no operation in flight and no pending response

Behaviour:
- Reset (async, rstn=0):
  - req_ready=0, mul_a=0, mul_b=0.
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_z=0, idle=1.
  - RR pointer=0, all delay-line valid bits=0, in-flight counter=0.
- Arbitration:
  - Combinational. Among asserted req_valid, grant the first index at or after ptr, searching upward with wrap.
  - req_ready[g]=1 only for the granted g, and only when issue_en=1. A transfer occurs when req_valid[g]&req_ready[g].
  - After a transfer ptr <= (g+1) mod NUM_REQ; otherwise ptr holds.
  - req_ready never depends on downstream state; one grant per cycle max.
- Issue stage (registered): on transfer at cycle t, mul_a/mul_b <= req_a/req_b slice g at t+1. With no transfer, mul_a/mul_b <= 0.
- Delay line:
  - Entry {v, id, tag}, depth QPMM_LAT+1, shifting every cycle.
  - Entry inserted at t carries v=1, id=g and the request tag. Bubbles have v=0.
  - A transfer accepted at cycle t produces rsp_valid=1 at t+QPMM_LAT+2.
- Response (registered):
  - Head v=1: rsp_z <= mul_z, rsp_id/rsp_tag <= head fields, rsp_valid <= 1.
  - Head v=0: rsp_valid <= 0, and rsp_z/rsp_id/rsp_tag hold their previous values.
- In-flight counter, width clog2(QPMM_LAT+3):
  - +1 on transfer; -1 when rsp_valid is set; both in the same cycle leaves it unchanged.
  - idle = (count==0).
- Boundary cases:
  - Back-to-back grants every cycle, so full throughput.
  - Single requester holding valid is granted every cycle.
  - issue_en falling mid-stream: outstanding responses still all emerge in order.
  - Reset mid-operation drops all in-flight results; no spurious rsp_valid after rstn rises.
  - Counter never overflows, since at most QPMM_LAT+2 operations can be in flight.

Optional Feature:
- QPMM_ARB_PERF_EN defined:
  - Adds outputs perf_busy (32 b), incremented each cycle a transfer occurs.
  - Adds perf_stall (32 b), incremented each cycle some req_valid=1 while issue_en=0.
  - Both reset to 0 and saturate at all-ones.
- Undefined: these ports and counters are absent.

Decomposition:
- Package PARAMS_BN254_d0 (existing) supplies qpmm_fp_t / FP_W.
- New package additions: the arb_entry_t struct {v, id, tag} and the QPMM_LAT constant, derived from N, D and pipeline latency so it matches the multiplier build.
- One sub-module: rr_arbiter, a parameterized round-robin grant with pointer update, reusable by other shared-unit schedulers.

Test Plan:
- Bench multiplier model: delay line of QPMM_LAT returning A*B mod 2^256; QPMM_LAT=8 for the bench.
- Single request: r1 A=3 B=5 tag=7 at cycle 10 -> mul_a=3 at cycle 11; rsp_valid at cycle 20 with id=1, tag=7, z=15; idle=1 from cycle 21.
- All four requesters held valid for 8 cycles with ptr=0 -> grants in order 0,1,2,3,0,1,2,3. Responses appear on 8 consecutive cycles in the same order with matching tags.
- Requesters 0 and 2 valid only, ptr=1 -> grant 2 first, then 0, then 2. Requester 1/3 req_ready never asserted.
- issue_en=0 for cycles 5..9 with pending requests -> no req_ready asserted during that window. Already-issued responses still complete; grants resume at cycle 10 from the held pointer.
- Reset mid-operation: rstn=0 at cycle 6 with 4 in flight -> all outputs zero immediately. After release there is no rsp_valid until new requests arrive, and idle=1.
- With QPMM_ARB_PERF_EN defined: 12 transfers and 3 stall cycles -> perf_busy=12, perf_stall=3.

Source files
------------

// File: rtl/qpmm_issue_arbiter_pkg.sv
// Shared constants and bundles for the QPMM issue arbiter.
// QPMM_LAT_CFG tracks the multiplier build (N, D, per-stage latency).
package qpmm_issue_arbiter_pkg;

  localparam int QPMM_N         = 256;
  localparam int QPMM_D         = 16;
  localparam int QPMM_STAGE_LAT = 4;
  localparam int QPMM_LAT_CFG   = (QPMM_N / QPMM_D) * QPMM_STAGE_LAT;
  localparam int FP_W_CFG       = QPMM_N;

  // Wide enough for up to 8 requesters and 8-bit tags.
  localparam int ARB_ID_W  = 3;
  localparam int ARB_TAG_W = 8;

  typedef logic [FP_W_CFG-1:0] qpmm_fp_t;

  typedef struct packed {
    logic                 v;
    logic [ARB_ID_W-1:0]  id;
    logic [ARB_TAG_W-1:0] tag;
  } arb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant with pointer advance past the winner.
// Reusable by any shared-unit scheduler.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          xfer
);

  logic [IW-1:0] ptr;
  logic [IW:0]   j;
  logic          found;

  // First requester at or after ptr, searching upward with wrap.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(N))
        j = j - (IW+1)'(N);
      if (!found && req[j[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = j[IW-1:0];
      end
    end
    xfer = en && found;
    gnt  = '0;
    if (xfer)
      gnt[gnt_idx] = 1'b1;
  end

  // Pointer moves just past the winner on each transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ptr <= '0;
    else if (xfer)
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/qpmm_issue_arbiter.sv
// Shares one pipelined QPMM multiplier among NUM_REQ requesters.
// Define QPMM_ARB_PERF_EN to add perf_busy/perf_stall counters.
module qpmm_issue_arbiter
  import qpmm_issue_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int FP_W     = FP_W_CFG,
  parameter  int TAG_W    = 4,
  parameter  int QPMM_LAT = QPMM_LAT_CFG,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int CW       = $clog2(QPMM_LAT+3)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*FP_W-1:0]  req_a,
  input  logic [NUM_REQ*FP_W-1:0]  req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                     issue_en,
  output logic [FP_W-1:0]          mul_a,
  output logic [FP_W-1:0]          mul_b,
  input  logic [FP_W-1:0]          mul_z,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [FP_W-1:0]          rsp_z,
  output logic                     idle
`ifdef QPMM_ARB_PERF_EN
  ,
  output logic [31:0]              perf_busy,
  output logic [31:0]              perf_stall
`endif
);

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     g;
  logic               xfer;
  arb_entry_t         ins;
  arb_entry_t         dl [QPMM_LAT+1];
  logic [CW-1:0]      cnt;

  // Gating with rstn keeps req_ready low while reset is held.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .en      (issue_en & rstn),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (g),
    .xfer    (xfer)
  );

  assign req_ready = gnt;

  // Registered operand issue; zeros on bubble cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (xfer) begin
      mul_a <= req_a[g*FP_W +: FP_W];
      mul_b <= req_b[g*FP_W +: FP_W];
    end else begin
      mul_a <= '0;
      mul_b <= '0;
    end
  end

  // Entry that tracks this cycle's issue through the multiplier.
  always_comb begin
    ins = '0;
    if (xfer) begin
      ins.v   = 1'b1;
      ins.id  = ARB_ID_W'(g);
      ins.tag = ARB_TAG_W'(req_tag[g*TAG_W +: TAG_W]);
    end
  end

  // Latency-matched shift line; head lines up with mul_z.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= QPMM_LAT; i++)
        dl[i] <= '0;
    end else begin
      dl[0] <= ins;
      for (int i = 1; i <= QPMM_LAT; i++)
        dl[i] <= dl[i-1];
    end
  end

  // Response capture; fields hold on bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
      rsp_z     <= '0;
    end else begin
      rsp_valid <= dl[QPMM_LAT].v;
      if (dl[QPMM_LAT].v) begin
        rsp_z   <= mul_z;
        rsp_id  <= dl[QPMM_LAT].id[IDW-1:0];
        rsp_tag <= dl[QPMM_LAT].tag[TAG_W-1:0];
      end
    end
  end

  // In-flight count: issued but response not yet presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else
      case ({xfer, rsp_valid})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
  end

  assign idle = (cnt == '0);

`ifdef QPMM_ARB_PERF_EN
  // Saturating busy/stall counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (xfer && perf_busy != '1)
        perf_busy <= perf_busy + 1'b1;
      if (|req_valid && !issue_en && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qpmm_issue_arbiter.sv
// Self-checking bench for qpmm_issue_arbiter (QPMM_LAT=8).
// Table of arbitration vectors plus directed multi-cycle sequences.
module tb_qpmm_issue_arbiter;

  localparam int N   = 4;
  localparam int W   = 256;
  localparam int TW  = 4;
  localparam int LAT = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N*TW-1:0] req_tag;
  logic            issue_en;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [W-1:0]    mul_z;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [W-1:0]    rsp_z;
  logic            idle;
`ifdef QPMM_ARB_PERF_EN
  logic [31:0]     perf_busy;
  logic [31:0]     perf_stall;
`endif

  always #5 clk = ~clk;

  qpmm_issue_arbiter #(
    .NUM_REQ (N),
    .FP_W    (W),
    .TAG_W   (TW),
    .QPMM_LAT(LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .issue_en  (issue_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_z     (rsp_z),
    .idle      (idle)
`ifdef QPMM_ARB_PERF_EN
    ,
    .perf_busy (perf_busy),
    .perf_stall(perf_stall)
`endif
  );

  // Multiplier model: A*B mod 2^256 after LAT cycles.
  logic [W-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= mul_a * mul_b;
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end
  assign mul_z = pipe[LAT-1];

  typedef struct {
    int            id;
    logic [TW-1:0] tag;
    logic [W-1:0]  z;
    int            due;
  } exp_t;

  typedef struct {
    logic [N-1:0] v;
    logic         en;
    logic [N-1:0] rdy;
  } vec_t;

  exp_t          q[$];
  vec_t          tbl[16];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            exp_busy = 0;
  int            exp_stall = 0;
  logic [W-1:0]  exp_ma = '0;
  logic [W-1:0]  exp_mb = '0;
  logic [W-1:0]  cur_a [N];
  logic [W-1:0]  cur_b [N];
  logic [TW-1:0] cur_tag [N];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fill_ops();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < W/32; k++) begin
        cur_a[i][k*32 +: 32] = $urandom;
        cur_b[i][k*32 +: 32] = $urandom;
      end
      cur_tag[i] = TW'($urandom_range(0, 15));
    end
  endtask

  task automatic monitor();
    logic ev;
    check("mul_a", mul_a, exp_ma);
    check("mul_b", mul_b, exp_mb);
    check("idle", W'(idle), W'(q.size() == 0));
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("rsp_valid", W'(rsp_valid), W'(ev));
    if (ev) begin
      check("rsp_id", W'(rsp_id), W'(q[0].id));
      check("rsp_tag", W'(rsp_tag), W'(q[0].tag));
      check("rsp_z", rsp_z, q[0].z);
      void'(q.pop_front());
    end
  endtask

  // One cycle: drive, sample at negedge, model the expected transfer.
  task automatic run_cycle(input logic [N-1:0] v, input logic en,
                           input logic [N-1:0] er);
    int           g;
    logic [W-1:0] p;
    logic [W-1:0] nma;
    logic [W-1:0] nmb;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]    = cur_a[i];
      req_b[i*W +: W]    = cur_b[i];
      req_tag[i*TW +: TW] = cur_tag[i];
    end
    req_valid = v;
    issue_en  = en;
    @(negedge clk);
    check("req_ready", W'(req_ready), W'(er));
    monitor();
    nma = '0;
    nmb = '0;
    if (|(v & er)) begin
      g = 0;
      for (int i = 0; i < N; i++)
        if (er[i]) g = i;
      p = cur_a[g] * cur_b[g];
      q.push_back('{g, cur_tag[g], p, cyc + LAT + 2});
      nma = cur_a[g];
      nmb = cur_b[g];
      exp_busy++;
    end
    if (|v && !en)
      exp_stall++;
    @(posedge clk);
    cyc++;
    exp_ma = nma;
    exp_mb = nmb;
    #1;
    fill_ops();
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 4; i++)
      run_cycle('0, 1'b1, '0);
    check("drained", W'(q.size()), '0);
  endtask

  task automatic check_perf();
`ifdef QPMM_ARB_PERF_EN
    check("perf_busy", W'(perf_busy), W'(exp_busy));
    check("perf_stall", W'(perf_stall), W'(exp_stall));
`endif
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0110, 1'b0, 4'b0000};
    tbl[10] = '{4'b0110, 1'b1, 4'b0010};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000};
    tbl[12] = '{4'b0010, 1'b1, 4'b0010};
    tbl[13] = '{4'b0010, 1'b1, 4'b0010};
    tbl[14] = '{4'b1000, 1'b1, 4'b1000};
    tbl[15] = '{4'b1001, 1'b1, 4'b0001};

    req_valid = '0;
    issue_en  = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    fill_ops();

    // Reset state
    #2;
    check("rst_ready", W'(req_ready), '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_rsp_valid", W'(rsp_valid), '0);
    check("rst_rsp_z", rsp_z, '0);
    check("rst_idle", W'(idle), W'(1));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven arbitration sweep
    for (int i = 0; i < 16; i++)
      run_cycle(tbl[i].v, tbl[i].en, tbl[i].rdy);
    drain();

    // Single request: r1, 3*5, tag 7
    cur_a[1]   = 256'd3;
    cur_b[1]   = 256'd5;
    cur_tag[1] = 4'd7;
    run_cycle(4'b0010, 1'b1, 4'b0010);
    drain();

    // Bring ptr to 0, then all four held valid for 8 cycles
    run_cycle(4'b1000, 1'b1, 4'b1000);
    for (int k = 0; k < 8; k++)
      run_cycle(4'b1111, 1'b1, 4'(4'b0001 << (k % 4)));
    drain();

    // issue_en low mid-stream; pointer holds across the gap
    run_cycle(4'b1111, 1'b1, 4'b0001);
    run_cycle(4'b1111, 1'b1, 4'b0010);
    for (int k = 0; k < 5; k++)
      run_cycle(4'b1111, 1'b0, 4'b0000);
    run_cycle(4'b1111, 1'b1, 4'b0100);
    run_cycle(4'b1111, 1'b1, 4'b1000);
    drain();
    check_perf();

    // Reset with four operations in flight
    for (int k = 0; k < 4; k++)
      run_cycle(4'b1111, 1'b1, 4'(4'b0001 << k));
    rstn = 1'b0;
    #1;
    check("mrst_ready", W'(req_ready), '0);
    check("mrst_mul_a", mul_a, '0);
    check("mrst_mul_b", mul_b, '0);
    check("mrst_rsp_valid", W'(rsp_valid), '0);
    check("mrst_rsp_id", W'(rsp_id), '0);
    check("mrst_rsp_tag", W'(rsp_tag), '0);
    check("mrst_rsp_z", rsp_z, '0);
    check("mrst_idle", W'(idle), W'(1));
    q.delete();
    exp_ma    = '0;
    exp_mb    = '0;
    exp_busy  = 0;
    exp_stall = 0;
    req_valid = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    drain();
    check_perf();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
